alu_writeback_stage: RTL and testbench

- Pipeline stage directly downstream of the 8-bit ALU.
- Captures the ALU result and flags into a one-entry writeback register with a valid/ready handshake toward the register file.
- Holds the architectural C/N/Z flag register. The committed C flag feeds back to the ALU carry-chain ops (ADDC, SUBC, LSLC, LSRC).
- Resolves BLT/BNE and latches HALT.

---
 rtl/alu_writeback_stage.sv | 156 +++++++++++++++
 tb/tb_alu_writeback_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the 8-bit ALU: one-entry write register with a
// valid/ready handshake, architectural C/N/Z flags, branch resolution and halt.

package definitions;
  typedef enum logic [7:0] {
    ADD  = 8'd0,
    ADDC = 8'd1,
    SUB  = 8'd2,
    SUBC = 8'd3,
    LSL  = 8'd4,
    LSLC = 8'd5,
    LSR  = 8'd6,
    LSRC = 8'd7,
    ASR  = 8'd8,
    NEG  = 8'd9,
    AND  = 8'd10,
    OR   = 8'd11,
    CMP  = 8'd12,
    IMME = 8'd13,
    BLT  = 8'd14,
    BNE  = 8'd15,
    LW   = 8'd16,
    SW   = 8'd17,
    ALW  = 8'd18,
    ASW  = 8'd19,
    HALT = 8'd20
  } op_code;
endpackage

module alu_writeback_stage #(
  parameter int unsigned REG_AW      = 2,
  parameter logic [2:0]  RESET_FLAGS = 3'b000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [7:0]        op_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [7:0]        result_i,
  input  logic              carry_i,
  input  logic              neg_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [7:0]        wb_data_o,
  output logic              carry_flag_o,
  output logic              neg_flag_o,
  output logic              zero_flag_o,
  output logic              branch_taken_o,
  output logic              halt_o
);

  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_addr_q,  wb_addr_d;
  logic [7:0]        wb_data_q,  wb_data_d;
  logic              c_q, c_d;
  logic              n_q, n_d;
  logic              z_q, z_d;
  logic              br_q, br_d;
  logic              halt_q, halt_d;

  logic accept;
  logic wr_en, upd_c, upd_nz, is_blt, is_bne, is_halt;

  // Stage can take a new op unless halted or the write register is stuck.
  always_comb begin
    ex_ready_o = !halt_q && (!wb_valid_q || wb_ready_i);
    accept     = ex_valid_i && ex_ready_o;
  end

  // Opcode decode into write / flag-update / branch / halt controls.
  always_comb begin
    wr_en   = 1'b0;
    upd_c   = 1'b0;
    upd_nz  = 1'b0;
    is_blt  = 1'b0;
    is_bne  = 1'b0;
    is_halt = 1'b0;
    case (op_i)
      definitions::ADD,  definitions::ADDC, definitions::SUB,
      definitions::SUBC, definitions::LSL,  definitions::LSLC,
      definitions::LSR,  definitions::LSRC, definitions::ASR: begin
        wr_en  = 1'b1;
        upd_c  = 1'b1;
        upd_nz = 1'b1;
      end
      definitions::NEG, definitions::AND, definitions::OR: begin
        wr_en  = 1'b1;
        upd_nz = 1'b1;
      end
      definitions::CMP:  upd_nz  = 1'b1;
      definitions::IMME: wr_en   = 1'b1;
      definitions::BLT:  is_blt  = 1'b1;
      definitions::BNE:  is_bne  = 1'b1;
      definitions::HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Next-state: refill wins over drain so back-to-back writes stream.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (accept && wr_en) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = rd_i;
      wb_data_d  = result_i;
    end else if (wb_ready_i) begin
      wb_valid_d = 1'b0;
    end
    c_d    = (accept && upd_c)  ? carry_i            : c_q;
    n_d    = (accept && upd_nz) ? neg_i              : n_q;
    z_d    = (accept && upd_nz) ? (result_i == 8'h00) : z_q;
    // Branches resolve against the flags held before this edge.
    br_d   = accept && ((is_blt && n_q) || (is_bne && !z_q));
    halt_d = halt_q || (accept && is_halt);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      c_q        <= RESET_FLAGS[2];
      n_q        <= RESET_FLAGS[1];
      z_q        <= RESET_FLAGS[0];
      br_q       <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      c_q        <= c_d;
      n_q        <= n_d;
      z_q        <= z_d;
      br_q       <= br_d;
      halt_q     <= halt_d;
    end
  end

  // Output mapping.
  always_comb begin
    wb_valid_o     = wb_valid_q;
    wb_addr_o      = wb_addr_q;
    wb_data_o      = wb_data_q;
    carry_flag_o   = c_q;
    neg_flag_o     = n_q;
    zero_flag_o    = z_q;
    branch_taken_o = br_q;
    halt_o         = halt_q;
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: expected writes are queued on
// accept and popped when the register file consumes them.

module tb_alu_writeback_stage;
  import definitions::*;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b1;
  logic       ex_valid_i = 1'b0;
  logic       ex_ready_o;
  logic [7:0] op_i = 8'h00;
  logic [1:0] rd_i = 2'd0;
  logic [7:0] result_i = 8'h00;
  logic       carry_i = 1'b0;
  logic       neg_i = 1'b0;
  logic       wb_valid_o;
  logic       wb_ready_i = 1'b1;
  logic [1:0] wb_addr_o;
  logic [7:0] wb_data_o;
  logic       carry_flag_o, neg_flag_o, zero_flag_o;
  logic       branch_taken_o, halt_o;

  alu_writeback_stage #(.REG_AW(2), .RESET_FLAGS(3'b000)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .op_i(op_i), .rd_i(rd_i), .result_i(result_i),
    .carry_i(carry_i), .neg_i(neg_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .carry_flag_o(carry_flag_o), .neg_flag_o(neg_flag_o),
    .zero_flag_o(zero_flag_o), .branch_taken_o(branch_taken_o),
    .halt_o(halt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [1:0] a; logic [7:0] d; } wr_t;
  wr_t q[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state
  logic mc = 1'b0, mn = 1'b0, mz = 1'b0, mhalt = 1'b0, exp_br = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Consumed writes are compared against the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_n_i && wb_valid_o && wb_ready_i) begin
      if (q.size() == 0) check("wb_spurious", 1, 0);
      else begin
        wr_t e;
        e = q.pop_front();
        check("wb_addr_drain", wb_addr_o, e.a);
        check("wb_data_drain", wb_data_o, e.d);
      end
    end
  end

  task automatic model_accept();
    case (op_i)
      ADD, ADDC, SUB, SUBC, LSL, LSLC, LSR, LSRC, ASR: begin
        q.push_back('{a: rd_i, d: result_i});
        mc = carry_i; mn = neg_i; mz = (result_i == 8'h00);
      end
      NEG, AND, OR: begin
        q.push_back('{a: rd_i, d: result_i});
        mn = neg_i; mz = (result_i == 8'h00);
      end
      CMP:  begin mn = neg_i; mz = (result_i == 8'h00); end
      IMME: q.push_back('{a: rd_i, d: result_i});
      BLT:  exp_br = mn;
      BNE:  exp_br = !mz;
      HALT: mhalt = 1'b1;
      default: ;
    endcase
  endtask

  // Advance one clock and check all registered outputs.
  task automatic step();
    @(posedge clk_i); #1;
    check("wb_valid", wb_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      check("wb_addr", wb_addr_o, q[0].a);
      check("wb_data", wb_data_o, q[0].d);
    end
    check("carry", carry_flag_o, mc);
    check("neg", neg_flag_o, mn);
    check("zero", zero_flag_o, mz);
    check("branch", branch_taken_o, exp_br);
    check("halt", halt_o, mhalt);
    exp_br = 1'b0;
  endtask

  // One handshake cycle; entered at posedge+1 with inputs already driven.
  task automatic cycle(output bit acc);
    logic exp_rdy;
    #1;
    exp_rdy = !mhalt && (q.size() == 0 || wb_ready_i);
    check("ex_ready", ex_ready_o, exp_rdy);
    acc = ex_valid_i && exp_rdy;
    if (acc) model_accept();
    step();
    if (acc) ex_valid_i = 1'b0;
  endtask

  task automatic drive(input logic [7:0] op, input logic [1:0] rd,
                       input logic [7:0] res, input logic c, input logic n);
    ex_valid_i = 1'b1; op_i = op; rd_i = rd; result_i = res; carry_i = c; neg_i = n;
  endtask

  task automatic issue(input logic [7:0] op, input logic [1:0] rd,
                       input logic [7:0] res, input logic c, input logic n);
    bit acc;
    drive(op, rd, res, c, n);
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) cycle(acc);
    if (!acc) begin
      check("accept_timeout", 0, 1);
      ex_valid_i = 1'b0;
    end
  endtask

  task automatic idle(input int unsigned n);
    bit acc;
    ex_valid_i = 1'b0;
    for (int unsigned i = 0; i < n; i++) cycle(acc);
  endtask

  // Asserts reset away from the clock edge and checks outputs asynchronously.
  task automatic do_reset();
    rst_n_i = 1'b0;
    ex_valid_i = 1'b0;
    #1;
    q.delete();
    mc = 1'b0; mn = 1'b0; mz = 1'b0; mhalt = 1'b0; exp_br = 1'b0;
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_addr", wb_addr_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_flags", {carry_flag_o, neg_flag_o, zero_flag_o}, 3'b000);
    check("rst_branch", branch_taken_o, 0);
    check("rst_halt", halt_o, 0);
    check("rst_ex_ready", ex_ready_o, 1);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    #2;
    do_reset();

    // ADD fill and drain
    wb_ready_i = 1'b1;
    issue(ADD, 2'd2, 8'h00, 1'b1, 1'b0);
    check("add_flags", {carry_flag_o, neg_flag_o, zero_flag_o}, 3'b101);
    check("add_valid", wb_valid_o, 1);
    idle(1);
    check("add_drained", wb_valid_o, 0);

    // Backpressure
    wb_ready_i = 1'b0;
    issue(ADD, 2'd1, 8'h11, 1'b0, 1'b0);
    drive(ADD, 2'd3, 8'h22, 1'b1, 1'b0);
    cycle(acc);
    check("bp_not_accepted", acc, 0);
    cycle(acc);
    check("bp_hold_data", wb_data_o, 8'h11);
    wb_ready_i = 1'b1;
    cycle(acc);
    check("bp_refill_accept", acc, 1);
    check("bp_refill_data", wb_data_o, 8'h22);
    idle(1);

    // Logic op and CMP flags, C=1 from previous ADD
    issue(AND, 2'd0, 8'h80, 1'b0, 1'b1);
    check("and_flags", {carry_flag_o, neg_flag_o, zero_flag_o}, 3'b110);
    issue(CMP, 2'd1, 8'h05, 1'b0, 1'b0);
    check("cmp_flags", {carry_flag_o, neg_flag_o, zero_flag_o}, 3'b100);
    idle(1);
    check("cmp_no_write", wb_valid_o, 0);

    // Branch resolution
    issue(ADD, 2'd1, 8'h00, 1'b0, 1'b0);
    issue(BNE, 2'd0, 8'h00, 1'b0, 1'b0);
    check("bne_not_taken", branch_taken_o, 0);
    issue(CMP, 2'd0, 8'h80, 1'b0, 1'b1);
    issue(BLT, 2'd0, 8'h00, 1'b0, 1'b0);
    check("blt_taken", branch_taken_o, 1);
    idle(1);
    check("blt_pulse_end", branch_taken_o, 0);
    issue(BNE, 2'd0, 8'h00, 1'b0, 1'b0);
    check("bne_taken", branch_taken_o, 1);

    // IMME and unknown opcode
    issue(IMME, 2'd2, 8'hA5, 1'b1, 1'b1);
    issue(8'hFF, 2'd3, 8'h00, 1'b1, 1'b1);
    issue(LW, 2'd3, 8'h00, 1'b1, 1'b1);
    idle(2);

    // Randomised mix with random backpressure
    for (int k = 0; k < 40; k++) begin
      logic [7:0] op;
      logic [7:0] res;
      op  = 8'($urandom_range(0, 20));
      if (op == HALT) op = 8'hFF;
      res = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      drive(op, 2'($urandom), res, 1'($urandom), 1'($urandom));
      acc = 0;
      for (int i = 0; i < 30 && !acc; i++) begin
        wb_ready_i = 1'($urandom);
        cycle(acc);
      end
      if (!acc) begin
        check("rand_accept_timeout", 0, 1);
        ex_valid_i = 1'b0;
      end
    end
    wb_ready_i = 1'b1;
    idle(2);
    check("rand_drained", q.size(), 0);

    // HALT with a pending write
    wb_ready_i = 1'b0;
    issue(ADD, 2'd1, 8'h33, 1'b0, 1'b0);
    drive(HALT, 2'd0, 8'h00, 1'b0, 1'b0);
    cycle(acc);
    check("halt_blocked", acc, 0);
    wb_ready_i = 1'b1;
    cycle(acc);
    check("halt_accept", acc, 1);
    check("halt_set", halt_o, 1);
    check("halt_ready_low", ex_ready_o, 0);
    drive(ADD, 2'd2, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      check("halt_no_accept", acc, 0);
    end
    check("halt_33_drained", q.size(), 0);
    ex_valid_i = 1'b0;

    // Reset clears halt; then reset mid-transfer drops the pending write
    do_reset();
    wb_ready_i = 1'b0;
    issue(SUB, 2'd3, 8'h55, 1'b1, 1'b1);
    check("pre_reset_valid", wb_valid_o, 1);
    do_reset();
    wb_ready_i = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
